// File: rtl/ps2_kbd_rx.sv
`timescale 1ns/1ps
// ps2_kbd_rx: PS/2 keyboard receiver with a glitch filter, a frame checker
// and a small receive FIFO. Optionally folds the E0/F0 prefix bytes into
// flag bits on the following scan code.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   ps2_clk       - asynchronous PS/2 clock line
//   ps2_data      - asynchronous PS/2 data line
//   nextdata_n    - active-low pop strobe, honoured only while ready=1
//   err_clr       - clears the sticky error flags
//   data[9:0]     - FIFO head {ext, brk, code}; combinational, valid when ready=1
//   ready         - FIFO non-empty
//   level         - FIFO occupancy, 0 .. 2**FIFO_AW
//   overflow      - sticky, a received byte was dropped on a full FIFO
//   parity_err    - sticky, a frame failed odd parity
//   frame_err     - sticky, bad start bit, bad stop bit or timeout
module ps2_kbd_rx #(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000,
  parameter int COOKED     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             nextdata_n,
  input  logic             err_clr,
  output logic [9:0]       data,
  output logic             ready,
  output logic [FIFO_AW:0] level,
  output logic             overflow,
  output logic             parity_err,
  output logic             frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0] FULL_LVL  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0]       PFX_EXT   = 8'hE0;
  localparam logic [7:0]       PFX_BRK   = 8'hF0;
  localparam logic             COOK_EN   = (COOKED != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic filt_clk_r, filt_prev_r;
  logic [FW-1:0] filt_cnt_r;
  logic edge_s, timeout_s;
  state_t state_r, state_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic par_r, ext_r, brk_r;
  logic [TW-1:0] to_cnt_r;
  logic push_s, set_ext_s, set_brk_s, clr_pfx_s, frame_set_s, parity_set_s;
  logic [9:0] push_word_s;
  logic [9:0] mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0] level_r;
  logic ready_s, pop_s, full_s, wr_en_s, ovf_set_s;
  logic overflow_r, parity_err_r, frame_err_r;

  // Two-flop synchronisers for both PS/2 lines (idle-high reset values).
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_data;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Glitch filter: follow the synchronised clock only after FILTER_LEN
  // consecutive samples that differ from the current filtered value.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= {FW{1'b0}};
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r == filt_clk_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign edge_s    = filt_prev_r & ~filt_clk_r;
  // Timeout and edge are exclusive: an edge in the limit cycle restarts the count.
  assign timeout_s = (state_r != IDLE) && !edge_s && (to_cnt_r == TO_LAST);

  // Receive FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Receive FSM next-state logic; moves only on an edge pulse or a timeout.
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_s) begin
      state_nxt_s = IDLE;
    end else if (edge_s) begin
      case (state_r)
        IDLE:    state_nxt_s = dat_sync_r ? IDLE : DATA;
        DATA:    state_nxt_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_nxt_s = STOP;
        STOP:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Receive FSM outputs: frame verdict, prefix handling and FIFO push request.
  always_comb begin
    push_s       = 1'b0;
    set_ext_s    = 1'b0;
    set_brk_s    = 1'b0;
    clr_pfx_s    = 1'b0;
    frame_set_s  = timeout_s;
    parity_set_s = 1'b0;
    if (edge_s) begin
      case (state_r)
        IDLE: frame_set_s = dat_sync_r;
        STOP: begin
          if (!dat_sync_r) begin
            frame_set_s = 1'b1;
            clr_pfx_s   = 1'b1;
          end else if (!odd_ok(shift_r, par_r)) begin
            parity_set_s = 1'b1;
            clr_pfx_s    = 1'b1;
          end else if (COOK_EN && (shift_r == PFX_EXT)) begin
            set_ext_s = 1'b1;
          end else if (COOK_EN && (shift_r == PFX_BRK)) begin
            set_brk_s = 1'b1;
          end else begin
            push_s    = 1'b1;
            clr_pfx_s = 1'b1;
          end
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
    push_word_s = COOK_EN ? {ext_r, brk_r, shift_r} : {2'b00, shift_r};
  end

  // Frame datapath: bit counter, shift register, parity, timeout counter, prefix flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      to_cnt_r  <= {TW{1'b0}};
      ext_r     <= 1'b0;
      brk_r     <= 1'b0;
    end else begin
      if ((state_r == IDLE) || edge_s || timeout_s) begin
        to_cnt_r <= {TW{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
      if (edge_s) begin
        case (state_r)
          IDLE: bit_cnt_r <= 3'd0;
          DATA: begin
            shift_r   <= {dat_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY:  par_r <= dat_sync_r;
          default: bit_cnt_r <= bit_cnt_r;
        endcase
      end
      if (set_ext_s) begin
        ext_r <= 1'b1;
      end else if (set_brk_s) begin
        brk_r <= 1'b1;
      end else if (clr_pfx_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end
  end

  assign ready_s   = (level_r != {(FIFO_AW+1){1'b0}});
  assign pop_s     = ready_s & ~nextdata_n;
  assign full_s    = (level_r == FULL_LVL);
  // When full, a simultaneous pop frees the head slot, which is also the write slot.
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // FIFO storage (no reset; occupancy tracking makes stale entries invisible).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at 2**FIFO_AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      level_r  <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + (FIFO_AW+1)'(1);
        2'b01:   level_r <= level_r - (FIFO_AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      overflow_r   <= ovf_set_s    | (overflow_r   & ~err_clr);
      parity_err_r <= parity_set_s | (parity_err_r & ~err_clr);
      frame_err_r  <= frame_set_s  | (frame_err_r  & ~err_clr);
    end
  end

  assign data       = mem_r[rd_ptr_r];
  assign ready      = ready_s;
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FIFO_AW, default 3, FIFO depth = 2**FIFO_AW entries.
REQ-002 Parameter FILTER_LEN, default 4, consecutive equal samples before the filtered ps2_clk changes.
REQ-003 Parameter TIMEOUT, default 50000, clk cycles without a filtered falling edge before a partial frame is aborted.
REQ-004 Parameter COOKED, default 0; 0 = raw scan bytes, 1 = prefix-absorbing decode.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ps2_clk  in  1  asynchronous PS/2 clock line.
REQ-008 ps2_data  in  1  asynchronous PS/2 data line.
REQ-009 nextdata_n  in  1  active-low pop; honoured only while ready=1.
REQ-010 err_clr  in  1  clears sticky error flags.
REQ-011 data  out  10  FIFO head, {ext, brk, code[7:0]}; bits 9:8 always 0 when COOKED=0.
REQ-012 ready  out  1  FIFO non-empty.
REQ-013 level  out  FIFO_AW+1  current FIFO occupancy.
REQ-014 overflow  out  1  sticky; a byte was dropped because the FIFO was full.
REQ-015 parity_err  out  1  sticky; a frame failed odd parity.
REQ-016 frame_err  out  1  sticky; bad start bit, bad stop bit, or timeout.

Function
REQ-017 ps2_clk and ps2_data each pass through a 2-flop synchroniser; the reset value of every flop is 1.
REQ-018 Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples; its reset value is 1.
REQ-019 Edge pulse: a one-cycle pulse on a filtered 1->0 transition; the synchronised ps2_data is sampled in that same cycle.
REQ-020 Receive FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on an edge pulse, except timeout.
REQ-021 IDLE: a sample of 0 goes to DATA with bit counter 0; a sample of 1 sets frame_err and the FSM stays in IDLE.
REQ-022 DATA: the sample shifts in LSB first; after the 8th bit the FSM goes to PARITY.
REQ-023 PARITY: the sample is stored; the FSM goes to STOP.
REQ-024 STOP: the frame is valid when stop=1 and XOR(data[7:0], parity)=1; the FSM goes to IDLE in every case.
REQ-025 Invalid frame: stop=0 sets frame_err, otherwise parity_err is set; the byte is discarded and the COOKED prefix flags are cleared.
REQ-026 Timeout: in any state other than IDLE, a count of TIMEOUT cycles since the last edge pulse forces IDLE and sets frame_err; the counter restarts on every edge pulse.
REQ-027 COOKED=0: every valid byte is pushed as {2'b00, byte}.
REQ-028 COOKED=1: byte 0xE0 sets ext_pend and 0xF0 sets brk_pend, with no push; any other byte pushes {ext_pend, brk_pend, byte} and clears both flags.
REQ-029 A push is written at the clk edge where the STOP edge pulse is high; ready and level reflect it from the next cycle.
REQ-030 Pop: with ready=1 and nextdata_n=0, the read pointer advances and data shows the next entry the following cycle.
REQ-031 Pop with ready=0 is ignored, and level never underflows.
REQ-032 Push when full with no pop in the same cycle: the new byte is dropped, overflow is set, and the FIFO contents are unchanged.
REQ-033 Push and pop in the same cycle, full or not: both are accepted, level is unchanged, and overflow is not set.
REQ-034 Pointers wrap modulo 2**FIFO_AW; level ranges from 0 to 2**FIFO_AW inclusive.
REQ-035 err_clr=1 clears overflow, parity_err and frame_err; if an error event occurs in the same cycle, the set wins.
REQ-036 data is combinational from the FIFO head and is a don't-care when ready=0.

Reset
REQ-037 rst=1 sampled on a clk edge gives: FSM IDLE, counters 0, pointers 0, level=0, ready=0, all error flags 0, prefix flags 0, synchroniser/filter flops 1.
REQ-038 rst asserted mid-frame aborts the frame without setting any flag; FIFO contents are discarded.

Verification
REQ-039 COOKED=0, frame 0x1C with parity 0 and stop 1 -> data=0x01C, ready=1, level=1 one cycle after the stop edge; no flags set.
REQ-040 COOKED=1, frames E0, F0, 75 -> exactly one entry, data=0x375, level=1; a following frame 75 -> entry 0x075.
REQ-041 Frame 0x1C with parity 1 -> parity_err=1, level=0; after err_clr pulse, parity_err=0.
REQ-042 FIFO_AW=3, 9 valid frames 0x01..0x09 with no pop -> level=8, overflow=1, head=0x01; 8 pops -> 0x01..0x08 in order, then ready=0.
REQ-043 Start bit plus 3 data bits, then line idle for TIMEOUT+5 cycles -> frame_err=1, FSM IDLE; a following valid frame 0x5A is accepted.
REQ-044 FILTER_LEN=4, 2-cycle low glitch on ps2_clk while idle -> no edge pulse, FSM stays IDLE, no flags set.
